// File: rtl/gcn_matrix_mem_server.sv
// gcn_matrix_mem_server
//   Weight / feature / COO row storage serving the GCN core's row-wide read
//   port through a READ_LATENCY-deep pipeline, plus a row-load port.
//   Optional statistics counters are built when MEM_SERVER_STATS_EN is defined.
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_load_en/sel/row/data  one-row write port (sel 0 weight, 1 feature, 2 COO)
//   o_load_error          1-cycle pulse for a bad load row or sel = 3
//   i_enable_read, i_read_address  unified read request
//   o_data_out, o_data_valid, o_addr_error  pipelined read result
//   i_coo_address, o_coo_out  combinational COO entry read ({src, dst})
//   o_read_count, o_error_count  saturating statistics (0 when disabled)
module gcn_matrix_mem_server #(
    parameter int unsigned FEATURE_ROWS  = 6,
    parameter int unsigned WEIGHT_COLS   = 3,
    parameter int unsigned ROW_LEN       = 96,
    parameter int unsigned DATA_WIDTH    = 5,
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned FEATURE_BASE  = 512,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned COO_COLS      = 6,
    parameter int unsigned COO_BW        = $clog2(COO_COLS)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_load_en,
    input  logic [1:0]                    i_load_sel,
    input  logic [ADDRESS_WIDTH-1:0]      i_load_row,
    input  logic [ROW_LEN*DATA_WIDTH-1:0] i_load_data,
    output logic                          o_load_error,
    input  logic                          i_enable_read,
    input  logic [ADDRESS_WIDTH-1:0]      i_read_address,
    output logic [ROW_LEN*DATA_WIDTH-1:0] o_data_out,
    output logic                          o_data_valid,
    output logic                          o_addr_error,
    input  logic [COO_BW-1:0]             i_coo_address,
    output logic [2*COO_BW-1:0]           o_coo_out,
    output logic [15:0]                   o_read_count,
    output logic [15:0]                   o_error_count
);

    localparam int unsigned ROW_W = ROW_LEN * DATA_WIDTH;
    localparam int unsigned WI_W  = (WEIGHT_COLS  > 1) ? $clog2(WEIGHT_COLS)  : 1;
    localparam int unsigned FI_W  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
    localparam int unsigned CI_W  = (COO_COLS     > 1) ? $clog2(COO_COLS)     : 1;

    localparam logic [ADDRESS_WIDTH-1:0] W_END   = ADDRESS_WIDTH'(WEIGHT_COLS);
    localparam logic [ADDRESS_WIDTH-1:0] F_BASE  = ADDRESS_WIDTH'(FEATURE_BASE);
    localparam logic [ADDRESS_WIDTH-1:0] F_END   = ADDRESS_WIDTH'(FEATURE_BASE + FEATURE_ROWS);
    localparam logic [ADDRESS_WIDTH-1:0] F_ROWS  = ADDRESS_WIDTH'(FEATURE_ROWS);
    localparam logic [ADDRESS_WIDTH-1:0] C_ROWS  = ADDRESS_WIDTH'(COO_COLS);
    localparam logic [COO_BW:0]          C_LIMIT = (COO_BW+1)'(COO_COLS);

    // Storage: never reset, filled through the load port
    logic [ROW_W-1:0]    r_weight  [WEIGHT_COLS];
    logic [ROW_W-1:0]    r_feature [FEATURE_ROWS];
    logic [2*COO_BW-1:0] r_coo     [COO_COLS];

    // Read pipeline; the last stage is the output register
    logic             r_vld [READ_LATENCY];
    logic             r_err [READ_LATENCY];
    logic [ROW_W-1:0] r_dat [READ_LATENCY];
    logic             r_load_error;

    logic             w_is_weight;
    logic             w_is_feature;
    logic             w_rd_err;
    logic [ROW_W-1:0] w_rd_data;
    logic             w_ld_weight;
    logic             w_ld_feature;
    logic             w_ld_coo;
    logic             w_ld_bad;

    // Address decode against the unified map
    assign w_is_weight  = (i_read_address < W_END);
    assign w_is_feature = (i_read_address >= F_BASE) && (i_read_address < F_END);
    assign w_rd_err     = !(w_is_weight || w_is_feature);

    always_comb begin
        w_rd_data = '0;
        if (w_is_weight)
            w_rd_data = r_weight[WI_W'(i_read_address)];
        else if (w_is_feature)
            w_rd_data = r_feature[FI_W'(i_read_address - F_BASE)];
    end

    // Load decode; reserved select or out-of-range row is an error
    assign w_ld_weight  = i_load_en && (i_load_sel == 2'd0) && (i_load_row < W_END);
    assign w_ld_feature = i_load_en && (i_load_sel == 2'd1) && (i_load_row < F_ROWS);
    assign w_ld_coo     = i_load_en && (i_load_sel == 2'd2) && (i_load_row < C_ROWS);
    assign w_ld_bad     = i_load_en && !(w_ld_weight || w_ld_feature || w_ld_coo);

    // Storage writes; non-blocking update gives read-before-write for free
    always_ff @(posedge i_clk) begin
        if (w_ld_weight)
            r_weight[WI_W'(i_load_row)] <= i_load_data;
        if (w_ld_feature)
            r_feature[FI_W'(i_load_row)] <= i_load_data;
        if (w_ld_coo)
            r_coo[CI_W'(i_load_row)] <= i_load_data[2*COO_BW-1:0];
    end

    // Data is captured at the accepting edge, then shifted; each stage only
    // takes new data with a valid so the output stage holds between results
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                r_vld[i] <= 1'b0;
                r_err[i] <= 1'b0;
                r_dat[i] <= '0;
            end
            r_load_error <= 1'b0;
        end else begin
            r_vld[0] <= i_enable_read;
            r_err[0] <= i_enable_read && w_rd_err;
            if (i_enable_read)
                r_dat[0] <= w_rd_data;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                if (r_vld[i-1])
                    r_dat[i] <= r_dat[i-1];
            end
            r_load_error <= w_ld_bad;
        end
    end

    assign o_data_valid = r_vld[READ_LATENCY-1];
    assign o_addr_error = r_err[READ_LATENCY-1];
    assign o_data_out   = r_dat[READ_LATENCY-1];
    assign o_load_error = r_load_error;

    // COO entries past the table read as zero
    assign o_coo_out = ({1'b0, i_coo_address} < C_LIMIT) ? r_coo[CI_W'(i_coo_address)] : '0;

`ifdef MEM_SERVER_STATS_EN
    logic [15:0] r_read_count;
    logic [15:0] r_error_count;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Error events are counted as their pulses appear on the outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_read_count  <= '0;
            r_error_count <= '0;
        end else begin
            r_read_count  <= sat_add(r_read_count, {1'b0, i_enable_read});
            r_error_count <= sat_add(r_error_count,
                                     2'(o_addr_error && o_data_valid) + 2'(r_load_error));
        end
    end

    assign o_read_count  = r_read_count;
    assign o_error_count = r_error_count;
`else
    assign o_read_count  = '0;
    assign o_error_count = '0;
`endif

endmodule

// File: tb/tb_gcn_matrix_mem_server.sv
// Scoreboard bench: two servers (read latency 1 and 3) share one stimulus
// stream; expected rows come from a plain array model of the three stores.
module tb_gcn_matrix_mem_server;

    localparam int RW = 96 * 5;

    typedef struct {
        logic [RW-1:0] data;
        logic          err;
    } rsp_t;

    logic          clk;
    logic          reset;
    logic          load_en;
    logic [1:0]    load_sel;
    logic [12:0]   load_row;
    logic [RW-1:0] load_data;
    logic          enable_read;
    logic [12:0]   read_address;
    logic [2:0]    coo_address;

    logic          lerr   [2];
    logic [RW-1:0] dout   [2];
    logic          dvld   [2];
    logic          aerr   [2];
    logic [5:0]    coo    [2];
    logic [15:0]   rcnt   [2];
    logic [15:0]   ecnt   [2];

    gcn_matrix_mem_server #(.READ_LATENCY(1)) u_lat1 (
        .i_clk(clk), .i_reset(reset),
        .i_load_en(load_en), .i_load_sel(load_sel), .i_load_row(load_row),
        .i_load_data(load_data), .o_load_error(lerr[0]),
        .i_enable_read(enable_read), .i_read_address(read_address),
        .o_data_out(dout[0]), .o_data_valid(dvld[0]), .o_addr_error(aerr[0]),
        .i_coo_address(coo_address), .o_coo_out(coo[0]),
        .o_read_count(rcnt[0]), .o_error_count(ecnt[0])
    );

    gcn_matrix_mem_server #(.READ_LATENCY(3)) u_lat3 (
        .i_clk(clk), .i_reset(reset),
        .i_load_en(load_en), .i_load_sel(load_sel), .i_load_row(load_row),
        .i_load_data(load_data), .o_load_error(lerr[1]),
        .i_enable_read(enable_read), .i_read_address(read_address),
        .o_data_out(dout[1]), .o_data_valid(dvld[1]), .o_addr_error(aerr[1]),
        .i_coo_address(coo_address), .o_coo_out(coo[1]),
        .o_read_count(rcnt[1]), .o_error_count(ecnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [RW-1:0] m_w [3];
    logic [RW-1:0] m_f [6];
    logic [5:0]    m_c [6];
    int            m_reads;
    int            m_errs;
    logic          exp_lerr;
    rsp_t          q [2][$];
    logic [RW-1:0] last_out [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic rsp_t model_read(input logic [12:0] a);
        rsp_t r;
        r.data = '0;
        r.err  = 1'b0;
        if (a < 3)
            r.data = m_w[a];
        else if (a >= 512 && a < 518)
            r.data = m_f[a - 512];
        else
            r.err = 1'b1;
        return r;
    endfunction

    function automatic logic [RW-1:0] pattern(input int mode);
        logic [RW-1:0] v;
        v = '0;
        for (int k = 0; k < 96; k++) begin
            case (mode)
                0: v[k*5 +: 5] = 5'd7;
                1: v[k*5 +: 5] = 5'(k % 32);
                2: v[k*5 +: 5] = 5'd31;
                3: v[k*5 +: 5] = 5'd0;
                default: v[k*5 +: 5] = 5'($urandom_range(0, 31));
            endcase
        end
        return v;
    endfunction

    // One stimulus cycle: drive at negedge, record expectations, then advance the model
    task automatic cyc(input logic le, input logic [1:0] ls, input logic [12:0] lr,
                       input logic [RW-1:0] ld, input logic re, input logic [12:0] ra);
        rsp_t r;
        logic [2:0] ca;
        logic [5:0] cexp;
        @(negedge clk);
        load_en = le; load_sel = ls; load_row = lr; load_data = ld;
        enable_read = re; read_address = ra;
        ca = 3'($urandom_range(0, 7));
        coo_address = ca;
        if (re) begin
            r = model_read(ra);
            q[0].push_back(r);
            q[1].push_back(r);
            m_reads++;
            if (r.err) m_errs++;
        end
        #1;
        cexp = (ca < 6) ? m_c[ca] : 6'd0;
        chk("coo_lat1", RW'(coo[0]), RW'(cexp));
        chk("coo_lat3", RW'(coo[1]), RW'(cexp));
        exp_lerr = 1'b0;
        if (le) begin
            if (ls == 2'd0 && lr < 3)      m_w[lr] = ld;
            else if (ls == 2'd1 && lr < 6) m_f[lr] = ld;
            else if (ls == 2'd2 && lr < 6) m_c[lr] = ld[5:0];
            else begin
                exp_lerr = 1'b1;
                m_errs++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 2'd0, 13'd0, '0, 1'b0, 13'd0);
    endtask

    // Reset discards in-flight reads; the model drops its expectations with it
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1; load_en = 1'b0; enable_read = 1'b0;
        q[0].delete(); q[1].delete();
        m_reads = 0; m_errs = 0; exp_lerr = 1'b0;
        repeat (n) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk("reset_valid", RW'(dvld[p]), RW'(1'b0));
            chk("reset_data", dout[p], '0);
            chk("reset_rcnt", RW'(rcnt[p]), '0);
            chk("reset_ecnt", RW'(ecnt[p]), '0);
        end
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a result retires, else checks hold
    always @(posedge clk) begin
        rsp_t e;
        #1;
        for (int p = 0; p < 2; p++) begin
            if (reset) last_out[p] = '0;
            if (dvld[p]) begin
                if (q[p].size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_valid port %0d at %0t: got valid=1 expected none", p, $time);
                end else begin
                    e = q[p].pop_front();
                    chk(p == 0 ? "data_lat1" : "data_lat3", dout[p], e.data);
                    chk(p == 0 ? "aerr_lat1" : "aerr_lat3", RW'(aerr[p]), RW'(e.err));
                    last_out[p] = e.data;
                end
            end else begin
                chk(p == 0 ? "hold_lat1" : "hold_lat3", dout[p], last_out[p]);
            end
            chk(p == 0 ? "lerr_lat1" : "lerr_lat3", RW'(lerr[p]), RW'(exp_lerr));
        end
    end

    initial begin
        logic [12:0] bnd [4];
        logic [12:0] a;
        logic [12:0] lr;
        bnd[0] = 13'd3; bnd[1] = 13'd511; bnd[2] = 13'd518; bnd[3] = 13'd8191;
        reset = 1'b0; load_en = 1'b0; load_sel = 2'd0; load_row = '0; load_data = '0;
        enable_read = 1'b0; read_address = '0; coo_address = '0;
        exp_lerr = 1'b0; m_reads = 0; m_errs = 0;
        last_out[0] = '0; last_out[1] = '0;
        for (int i = 0; i < 3; i++) m_w[i] = '0;
        for (int i = 0; i < 6; i++) begin m_f[i] = '0; m_c[i] = '0; end

        do_reset(3);

        // Fill every store so the model knows all contents
        cyc(1'b1, 2'd0, 13'd0, pattern(4), 1'b0, 13'd0);
        cyc(1'b1, 2'd0, 13'd1, pattern(4), 1'b0, 13'd0);
        cyc(1'b1, 2'd0, 13'd2, pattern(0), 1'b0, 13'd0);
        cyc(1'b1, 2'd1, 13'd0, pattern(3), 1'b0, 13'd0);
        for (int i = 1; i < 5; i++) cyc(1'b1, 2'd1, 13'(i), pattern(4), 1'b0, 13'd0);
        cyc(1'b1, 2'd1, 13'd5, pattern(1), 1'b0, 13'd0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 2'd2, 13'(i), pattern(4), 1'b0, 13'd0);

        // Directed reads: weight row 2, feature row 5, out-of-range, back-to-back
        cyc(1'b0, 2'd0, 13'd0, '0, 1'b1, 13'd2);
        idle(4);
        cyc(1'b0, 2'd0, 13'd0, '0, 1'b1, 13'd517);
        cyc(1'b0, 2'd0, 13'd0, '0, 1'b1, 13'd518);
        idle(4);
        cyc(1'b0, 2'd0, 13'd0, '0, 1'b1, 13'd0);
        cyc(1'b0, 2'd0, 13'd0, '0, 1'b1, 13'd1);
        cyc(1'b0, 2'd0, 13'd0, '0, 1'b1, 13'd2);
        idle(5);

        // Same-cycle load and read of feature row 0 returns the old row
        cyc(1'b1, 2'd1, 13'd0, pattern(2), 1'b1, 13'd512);
        cyc(1'b0, 2'd0, 13'd0, '0, 1'b1, 13'd512);
        idle(2);
        // Bad loads: reserved select and out-of-range rows
        cyc(1'b1, 2'd3, 13'd0, pattern(4), 1'b0, 13'd0);
        cyc(1'b1, 2'd0, 13'd3, pattern(4), 1'b0, 13'd0);
        cyc(1'b1, 2'd2, 13'd6, pattern(4), 1'b0, 13'd0);
        idle(4);

        // Randomized mix of concurrent loads and reads
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: a = 13'($urandom_range(0, 2));
                1: a = 13'($urandom_range(512, 517));
                2: a = 13'($urandom_range(0, 8191));
                default: a = bnd[$urandom_range(0, 3)];
            endcase
            lr = ($urandom_range(0, 7) == 0) ? 13'($urandom_range(0, 8191))
                                              : 13'($urandom_range(0, 7));
            cyc(($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)), lr, pattern(4),
                ($urandom_range(0, 9) < 6), a);
        end
        idle(6);
        chk("drain_lat1", RW'(q[0].size()), '0);
        chk("drain_lat3", RW'(q[1].size()), '0);

        // Reset with reads still in flight
        cyc(1'b0, 2'd0, 13'd0, '0, 1'b1, 13'd1);
        cyc(1'b0, 2'd0, 13'd0, '0, 1'b1, 13'd513);
        do_reset(2);
        idle(5);

        // Counter check: 10 reads (2 bad) and one reserved-select load
        for (int i = 0; i < 10; i++)
            cyc(i == 4, 2'd3, 13'd0, '0, 1'b1, (i == 3) ? 13'd3 : (i == 7) ? 13'd600 : 13'(i % 3));
        idle(8);
        for (int p = 0; p < 2; p++) begin
`ifdef MEM_SERVER_STATS_EN
            chk("read_count", RW'(rcnt[p]), RW'(m_reads));
            chk("error_count", RW'(ecnt[p]), RW'(m_errs));
`else
            chk("read_count", RW'(rcnt[p]), '0);
            chk("error_count", RW'(ecnt[p]), '0);
`endif
        end
        chk("drain_end_lat1", RW'(q[0].size()), '0);
        chk("drain_end_lat3", RW'(q[1].size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
